// File: rtl/config_usb_pkg.sv
// Shared definitions for the DFU configuration path (download and upload engines).
package config_usb_pkg;

    // DFU status codes reported to the host
    localparam logic [3:0] DFU_STATUS_OK          = 4'h0;
    localparam logic [3:0] DFU_STATUS_ERR_TARGET  = 4'h1;
    localparam logic [3:0] DFU_STATUS_ERR_UNKNOWN = 4'hE;

    // Alternate settings of the DFU interface
    localparam logic [2:0] DFU_ALT_CONFIG = 3'b000;
    localparam logic [2:0] DFU_ALT_UPLOAD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } dfu_state_e;

    // Byte idx of a word, most significant byte first
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/config_usb_word_fifo.sv
// Synchronous FIFO with occupancy count; clear flushes all entries.
module config_usb_word_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap freely
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/config_usb_upload.sv
// DFU upload engine: fetches readback words into a small FIFO and streams them
// MSB byte first onto the DFU IN byte stream.
module config_usb_upload
    import config_usb_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 4,
    parameter int         UPLOAD_WORDS = 4096,
    parameter logic [2:0] UPLOAD_ALT   = DFU_ALT_UPLOAD,
    parameter int         RB_TIMEOUT   = 255
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            dfu_mode_i,
    input  logic [2:0]                      dfu_alt_i,
    input  logic                            dfu_in_en_i,
    output logic [7:0]                      dfu_in_data_o,
    output logic                            dfu_in_valid_o,
    input  logic                            dfu_in_ready_i,
    input  logic                            dfu_clear_status_i,
    output logic                            rb_req_o,
    output logic [$clog2(UPLOAD_WORDS)-1:0] rb_addr_o,
    input  logic                            rb_valid_i,
    input  logic [31:0]                     rb_data_i,
    output logic                            dfu_busy_o,
    output logic [3:0]                      dfu_status_o,
    output logic                            done_o
);
    localparam int AW  = $clog2(UPLOAD_WORDS);
    localparam int CW  = AW + 1;
    localparam int TW  = $clog2(RB_TIMEOUT + 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    dfu_state_e     state;
    logic [CW-1:0]  words_requested;
    logic [CW-1:0]  words_sent;
    logic [1:0]     byte_idx;
    logic           outstanding;
    logic [TW-1:0]  tmo_cnt;

    logic           start;
    logic           issue;
    logic           xfer;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_clear;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;
    logic [31:0]    fifo_head;

    assign start = dfu_mode_i && (dfu_alt_i == UPLOAD_ALT) && dfu_in_en_i;

    // Single request in flight, and only when the FIFO has room for its answer
    assign issue = (state == ST_RUN) && start && !outstanding &&
                   (words_requested < CW'(UPLOAD_WORDS)) &&
                   (fifo_count < FCW'(FIFO_DEPTH));

    assign dfu_in_valid_o = (state == ST_RUN) && !fifo_empty;
    assign dfu_in_data_o  = fifo_empty ? 8'h00 : word_byte(fifo_head, byte_idx);
    assign xfer           = dfu_in_valid_o && dfu_in_ready_i;

    // Stray rb_valid_i (nothing outstanding, or after an abort) never reaches the FIFO
    assign fifo_push  = (state == ST_RUN) && outstanding && rb_valid_i;
    assign fifo_pop   = xfer && (byte_idx == 2'd3);
    assign fifo_clear = (state != ST_RUN) || !start;

    config_usb_word_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .reset (reset_i),
        .clear (fifo_clear),
        .push  (fifo_push),
        .din   (rb_data_i),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Upload FSM with concurrent fetch and send sides; all control outputs registered
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state           <= ST_IDLE;
            words_requested <= '0;
            words_sent      <= '0;
            byte_idx        <= '0;
            outstanding     <= 1'b0;
            tmo_cnt         <= '0;
            rb_req_o        <= 1'b0;
            rb_addr_o       <= '0;
            dfu_busy_o      <= 1'b0;
            dfu_status_o    <= DFU_STATUS_OK;
            done_o          <= 1'b0;
        end else begin
            rb_req_o <= 1'b0;

            // Error status stays visible while the host still holds the upload request
            if (dfu_clear_status_i && (state == ST_IDLE || state == ST_DONE ||
                                       (state == ST_ERROR && !dfu_in_en_i)))
                dfu_status_o <= DFU_STATUS_OK;

            case (state)
                ST_IDLE: begin
                    words_requested <= '0;
                    words_sent      <= '0;
                    byte_idx        <= '0;
                    outstanding     <= 1'b0;
                    tmo_cnt         <= '0;
                    done_o          <= 1'b0;
                    if (start && dfu_status_o == DFU_STATUS_OK) begin
                        state      <= ST_RUN;
                        dfu_busy_o <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!start) begin
                        state        <= ST_ERROR;
                        dfu_status_o <= DFU_STATUS_ERR_UNKNOWN;
                        dfu_busy_o   <= 1'b0;
                        outstanding  <= 1'b0;
                    end else if (outstanding && !rb_valid_i && tmo_cnt == TW'(RB_TIMEOUT)) begin
                        state        <= ST_ERROR;
                        dfu_status_o <= DFU_STATUS_ERR_TARGET;
                        dfu_busy_o   <= 1'b0;
                        outstanding  <= 1'b0;
                    end else if (words_sent == CW'(UPLOAD_WORDS)) begin
                        state      <= ST_DONE;
                        done_o     <= 1'b1;
                        dfu_busy_o <= 1'b0;
                    end else begin
                        if (issue) begin
                            rb_req_o        <= 1'b1;
                            rb_addr_o       <= words_requested[AW-1:0];
                            words_requested <= words_requested + CW'(1);
                            outstanding     <= 1'b1;
                            tmo_cnt         <= '0;
                        end else if (outstanding) begin
                            if (rb_valid_i) begin
                                outstanding <= 1'b0;
                                tmo_cnt     <= '0;
                            end else begin
                                tmo_cnt <= tmo_cnt + TW'(1);
                            end
                        end
                        if (xfer) begin
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) words_sent <= words_sent + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!dfu_in_en_i) begin
                        state  <= ST_IDLE;
                        done_o <= 1'b0;
                    end
                end
                default: begin
                    if (!dfu_in_en_i) state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
